// File: rtl/seq_mul_div_unit_if.sv
// Handshake and result bundle for the iterative HI/LO multiply/divide unit.
// The master drives requests; the slave (the unit) returns busy/done and HI/LO.
interface seq_mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] data_x;
  logic [WIDTH-1:0] data_y;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, data_x, data_y, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, data_x, data_y, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/seq_mul_div_unit.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one bit
// per cycle, with sign fix-up in a final cycle and direct MTHI/MTLO writes.
module seq_mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_mul_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               is_div_reg;
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div_zero_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               signed_op;

  // acc_reg holds {partial product, multiplier} for multiply and
  // {remainder, dividend/quotient} for divide; opnd_reg is the other operand.
  always_comb begin
    signed_op = (bus.op == 3'd0) || (bus.op == 3'd2);
    x_mag     = (signed_op && bus.data_x[WIDTH-1]) ? -bus.data_x : bus.data_x;
    y_mag     = (signed_op && bus.data_y[WIDTH-1]) ? -bus.data_y : bus.data_y;
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_reg[0] ? opnd_reg : {WIDTH{1'b0}})};
    div_trial = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, opnd_reg};
    if (is_div_reg) begin
      if (div_diff[WIDTH])
        acc_next = {div_trial[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      else
        acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
    acc_neg = -acc_reg;
    quo_fix = div_zero_reg ? {WIDTH{1'b1}}
            : (neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0]);
    // With a zero divisor the remainder magnitude is |x|, so the sign fix
    // alone reproduces the original dividend.
    rem_fix = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            case (bus.op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                state_reg    <= RUN;
                busy_reg     <= 1'b1;
                cnt_reg      <= '0;
                is_div_reg   <= bus.op[1];
                neg_q_reg    <= signed_op && (bus.data_x[WIDTH-1] ^ bus.data_y[WIDTH-1]);
                neg_r_reg    <= signed_op && bus.data_x[WIDTH-1];
                div_zero_reg <= (bus.data_y == '0);
                if (bus.op[1]) begin
                  acc_reg  <= {{WIDTH{1'b0}}, x_mag};
                  opnd_reg <= y_mag;
                end else begin
                  acc_reg  <= {{WIDTH{1'b0}}, y_mag};
                  opnd_reg <= x_mag;
                end
              end
              3'd4: begin
                hi_reg   <= bus.data_x;
                done_reg <= 1'b1;
              end
              3'd5: begin
                lo_reg   <= bus.data_x;
                done_reg <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (bus.cancel) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
          end else begin
            acc_reg <= acc_next;
            if (cnt_reg == CW'(WIDTH - 1)) begin
              state_reg <= FIX;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        FIX: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!bus.cancel) begin
            done_reg <= 1'b1;
            if (is_div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else begin
              {hi_reg, lo_reg} <= neg_q_reg ? acc_neg : acc_reg;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Scoreboard bench for seq_mul_div_unit: a 32-bit instance with a reference
// model of HI/LO, plus an 8-bit instance for the narrow-width latency case.
module tb_seq_mul_div_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_mul_div_unit_if #(.WIDTH(32)) b32 ();
  seq_mul_div_unit_if #(.WIDTH(8))  b8 ();

  seq_mul_div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  seq_mul_div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  sb_t         sb_e;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] ch,
                                        input logic [31:0] cl);
    logic signed [63:0] sx, sy, sp, sq, sr;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (op)
      3'd0: begin sp = sx * sy; return sp; end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      3'd4: return {x, cl};
      3'd5: return {ch, x};
      default: return {ch, cl};
    endcase
  endfunction

  task automatic push_op(input string tag, input logic [2:0] op,
                         input logic [31:0] x, input logic [31:0] y);
    sb_t e;
    e.tag = tag;
    e.exp = model(op, x, y, model_hi, model_lo);
    {model_hi, model_lo} = e.exp;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    b32.start  = 1'b1;
    b32.op     = op;
    b32.data_x = x;
    b32.data_y = y;
    @(negedge clk);
    b32.start  = 1'b0;
    b32.op     = 3'd7;
    b32.data_x = $urandom;
    b32.data_y = $urandom;
  endtask

  task automatic wait_idle(input string tag, input int exp_busy);
    int cyc = 0;
    while (b32.busy === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
    check({tag, "_done"}, 64'(b32.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] x, input logic [31:0] y);
    push_op(tag, op, x, y);
    issue(op, x, y);
    wait_idle(tag, (op < 3'd4) ? 33 : 0);
  endtask

  // Every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (rst_n && b32.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'(b32.done), 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check(sb_e.tag, {b32.hi, b32.lo}, sb_e.exp);
      end
    end
  end

  initial begin
    int cyc;
    b32.start = 1'b0; b32.op = 3'd7; b32.data_x = '0; b32.data_y = '0; b32.cancel = 1'b0;
    b8.start  = 1'b0; b8.op  = 3'd7; b8.data_x  = '0; b8.data_y  = '0; b8.cancel  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(b32.busy), 64'd0);
    check("reset_done", 64'(b32.done), 64'd0);
    check("reset_hi", 64'(b32.hi), 64'd0);
    check("reset_lo", 64'(b32.lo), 64'd0);
    rst_n = 1'b1;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_zero", 3'd3, 32'd7, 32'd0);
    run_op("div_zero_neg", 3'd2, 32'hFFFF_FFF9, 32'd0);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // MTHI immediately followed by MTLO: two consecutive done pulses, never busy.
    push_op("mthi", 3'd4, 32'h1234_5678, 32'd0);
    push_op("mtlo", 3'd5, 32'h9ABC_DEF0, 32'd0);
    @(negedge clk);
    b32.start = 1'b1; b32.op = 3'd4; b32.data_x = 32'h1234_5678;
    @(negedge clk);
    check("mthi_done", 64'(b32.done), 64'd1);
    b32.op = 3'd5; b32.data_x = 32'h9ABC_DEF0;
    @(negedge clk);
    b32.start = 1'b0; b32.op = 3'd7;
    check("mtlo_done", 64'(b32.done), 64'd1);
    check("mt_busy", 64'(b32.busy), 64'd0);
    check("mt_hilo", {b32.hi, b32.lo}, 64'h1234_5678_9ABC_DEF0);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  rop;
      logic [31:0] rx, ry;
      rop = 3'($urandom_range(0, 3));
      rx  = $urandom;
      ry  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, rx, ry);
    end

    // Cancel part way through RUN: no done, HI/LO untouched.
    issue(3'd3, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    b32.cancel = 1'b1;
    @(negedge clk);
    b32.cancel = 1'b0;
    check("cancel_busy", 64'(b32.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("cancel_hilo", {b32.hi, b32.lo}, {model_hi, model_lo});

    // Start with cancel in IDLE is dropped.
    @(negedge clk);
    b32.start = 1'b1; b32.op = 3'd4; b32.data_x = 32'hDEAD_BEEF; b32.cancel = 1'b1;
    @(negedge clk);
    b32.start = 1'b0; b32.cancel = 1'b0; b32.op = 3'd7;
    check("cancel_start_busy", 64'(b32.busy), 64'd0);
    check("cancel_start_done", 64'(b32.done), 64'd0);
    check("cancel_start_hi", 64'(b32.hi), 64'(model_hi));

    // A second request while busy is ignored.
    push_op("busy_ignore", 3'd3, 32'd100, 32'd7);
    issue(3'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    b32.start = 1'b1; b32.op = 3'd1; b32.data_x = 32'hFFFF; b32.data_y = 32'd3;
    @(negedge clk);
    b32.start = 1'b0; b32.op = 3'd7;
    wait_idle("busy_ignore", 29);

    // No-op codes do nothing.
    issue(3'd6, 32'h5555_5555, 32'd1);
    check("noop_busy", 64'(b32.busy), 64'd0);
    check("noop_done", 64'(b32.done), 64'd0);
    repeat (2) @(negedge clk);

    // Reset mid-operation clears everything.
    issue(3'd0, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(b32.busy), 64'd0);
    check("midrst_done", 64'(b32.done), 64'd0);
    check("midrst_hilo", {b32.hi, b32.lo}, 64'd0);
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    repeat (40) @(negedge clk);

    // WIDTH=8 instance: 0xFF * 0xFF with latency 9.
    @(negedge clk);
    b8.start = 1'b1; b8.op = 3'd1; b8.data_x = 8'hFF; b8.data_y = 8'hFF;
    @(negedge clk);
    b8.start = 1'b0; b8.op = 3'd7; b8.data_x = '0; b8.data_y = '0;
    cyc = 0;
    while (b8.busy === 1'b1 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("w8_busy_cycles", 64'(cyc), 64'd9);
    check("w8_done", 64'(b8.done), 64'd1);
    check("w8_hilo", 64'({b8.hi, b8.lo}), 64'h0000_0000_0000_FE01);

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
